inst_rom_loader: RTL

INST_ROM_LOADER -- requirements
Module: inst_rom_loader

---
 rtl/inst_rom_loader_if.sv | 26 ++
 rtl/inst_rom_loader.sv | 94 +++++++++
 2 files changed

// File: rtl/inst_rom_loader_if.sv
// Fetch and program-download bus between a core/loader (master) and inst_rom_loader (slave).
interface inst_rom_loader_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  ce;
    logic [31:0]           addr;
    logic [31:0]           inst;
    logic                  load_start;
    logic                  load_valid;
    logic [31:0]           load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_done;
    logic                  load_ovf;
    logic [DEPTH_LOG2:0]   load_count;

    modport master (
        output ce, addr, load_start, load_valid, load_data, load_last,
        input  inst, load_ready, load_done, load_ovf, load_count
    );

    modport slave (
        input  ce, addr, load_start, load_valid, load_data, load_last,
        output inst, load_ready, load_done, load_ovf, load_count
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction memory that is filled by a streamed download and then serves
// zero-latency fetches to the core; returns NOP whenever no valid program is live.
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    inst_rom_loader_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;

    logic [31:0]     mem [DEPTH];
    logic            accept;
    logic            last_slot;
    logic            addr_in_range;
    logic [31:0]     inst_w;

    // Write pointer and word count always advance together, so one register serves both.
    assign accept    = ready_q && bus.load_valid && !bus.load_start;
    assign last_slot = (cnt_q == CW'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (bus.load_start) begin
            state_d = LOAD;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            cnt_d = cnt_q + CW'(1);
            if (bus.load_last || last_slot) begin
                state_d = RUN;
                done_d  = 1'b1;
                if (!bus.load_last) begin
                    ovf_d = 1'b1;
                end
            end
        end
        ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Program storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[cnt_q[DEPTH_LOG2-1:0]] <= bus.load_data;
        end
    end

    assign addr_in_range = ((bus.addr >> (DEPTH_LOG2 + 2)) == 32'd0);

    always_comb begin
        inst_w = '0;
        if (state_q == RUN && bus.ce && addr_in_range) begin
            inst_w = mem[bus.addr[DEPTH_LOG2+1:2]];
        end
    end

    assign bus.inst       = inst_w;
    assign bus.load_ready = ready_q;
    assign bus.load_done  = done_q;
    assign bus.load_ovf   = ovf_q;
    assign bus.load_count = cnt_q;
endmodule
